multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 16-bit CPU datapath: steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath controls (RegDst, ALUsrc,
//  MemtoReg, RegWrite, MemWrite, Branch, ExtOp, ALUctr) plus PC/IR strobes.
//  Sits between the instruction register, the shared memory port and the register file/ALU.
//  Owns the memory request handshake and a retired-instruction counter.
// PARAMETERS
//  RET_W     16   width of retired-instruction counter (wraps)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  Run        in   1      1 = allow new fetch; 0 = hold in FETCH with MemReq low
//  Opcode     in   4      IR[15:12]; valid from DECODE onward
//  MemReady   in   1      memory ack; one-cycle pulse completes current MemReq
//  AluLt      in   1      ALU "rs < rt" flag, valid in EXEC of blt
//  MemReq     out  1      memory access request (instr fetch or data)
//  MemWrite   out  1      data write qualifier (with MemReq)
//  IRWrite    out  1      load IR (asserted in cycle MemReady seen in FETCH)
//  PCWrite    out  1      PC <= PC+1 (FETCH completion) or branch target
//  Branch     out  1      PC source = branch target (with PCWrite)
//  RegDst     out  1      1 = rd, 0 = rt
//  ALUsrc     out  1      1 = immediate
//  MemtoReg   out  1      1 = writeback from memory
//  RegWrite   out  1      register file write enable
//  ExtOp      out  1      1 = sign-extend, 0 = zero-extend
//  ALUctr     out  3      ALU operation
//  IllegalOp  out  1      sticky; set on opcode 1010-1111, cleared only by rst
//  State      out  3      current state encoding (debug)
//  RetCnt     out  RET_W  instructions retired
// BEHAVIOUR
//  Reset: State=FETCH, op_q=0, RetCnt=0, IllegalOp=0; all control outputs 0 during reset.
//  Outputs are Moore/decoded from State and op_q (registered in DECODE); all inactive
//   outputs are 0.
//  ISA: 0000 add(000) 0001 sub(001) 0010 and(010) 0011 or(011) 0101 xor(100) 0110 slt(101)
//   -> R-type RegDst=1; 0100 ori: ALUsrc=1, ExtOp=0, ALUctr=011; 0111 sw / 1000 lw:
//   ALUsrc=1, ExtOp=1, ALUctr=000; 1001 blt: ALUctr=001, ExtOp=1.
//  FETCH: MemReq=Run. If Run & MemReady: IRWrite=1, PCWrite=1 (Branch=0) -> DECODE;
//   otherwise stay. MemReq held until MemReady.
//  DECODE: latch op_q<=Opcode. 1010-1111: set IllegalOp, RetCnt+1 (treated as NOP) -> FETCH.
//   All others -> EXEC.
//  EXEC: ALUsrc/ExtOp/ALUctr per op_q. R-type/ori -> WB. lw/sw -> MEM.
//   blt: PCWrite=AluLt, Branch=AluLt, RetCnt+1 -> FETCH.
//  MEM: MemReq=1, MemWrite=(sw); ALU controls held. On MemReady: sw: RetCnt+1 -> FETCH;
//   lw -> WB. No MemReady -> stay (no timeout).
//  WB: RegWrite=1; MemtoReg=(lw); RegDst=R-type; RetCnt+1 -> FETCH.
//  Latency (zero wait): R/ori 4 cycles, lw 5, sw 4, blt 3, illegal 2.
//   Each memory wait adds 1 cycle per cycle MemReady is low.
//  MemReady outside FETCH/MEM is ignored. MemReady in FETCH with Run=0 is ignored.
//  RetCnt wraps 2^RET_W-1 -> 0. State encoding 5-7 unreachable; if entered -> FETCH next cycle.
//  rst mid-operation (incl. MEM with MemReq high): next cycle FETCH, all strobes 0;
//   no partial write issued after rst.
// STRUCTURE
//  Shared package cpu_pkg: opcode constants (OP_ADD..OP_BLT), ALUctr constants,
//   state encoding (S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4).
//  One sub-module: ctrl_decode (combinational op_q+State -> control word); FSM and counter
//   stay in top.
// TESTING
//  1. rst 2 cycles, Run=1, MemReady tied 1, op add: states 0,1,2,4,0; RegWrite=1 only in
//     cycle 4, ALUctr=000, RegDst=1; RetCnt=1.
//  2. lw with MemReady low 2 cycles in MEM: MemReq high 3 MEM cycles, MemWrite=0;
//     WB MemtoReg=1; total 7 cycles.
//  3. blt AluLt=1 -> EXEC PCWrite=1, Branch=1; AluLt=0 -> PCWrite=0; both 3 cycles.
//  4. Opcode 1100 -> IllegalOp=1 sticky, no RegWrite/MemReq after DECODE, RetCnt+1;
//     next add runs normally.
//  5. sw, assert rst in MEM while MemReady=0: next cycle State=0, MemReq=0, MemWrite=0;
//     RetCnt=0.
//  6. Run=0 in FETCH with MemReady=1: MemReq=0, IRWrite=0, State stays 0;
//     RET_W=4, 16 ori -> RetCnt wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, ALU codes, state encoding and control word for the multicycle CPU
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_ORI = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_BLT = 4'b1001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       regDst;
        logic       aluSrc;
        logic       memToReg;
        logic       regWrite;
        logic       extOp;
        logic [2:0] aluCtr;
    } ctrl_t;

    function automatic logic isIllegal(input logic [3:0] op);
        return op >= 4'b1010;
    endfunction

    function automatic logic isRType(input logic [3:0] op);
        return (op <= OP_OR) || (op == OP_XOR) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational state/opcode to datapath control word
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    output ctrl_t      ctrl
);

    logic [2:0] aluOp;
    logic       immOp;
    logic       signExt;

    always_comb begin
        aluOp   = ALU_ADD;
        immOp   = 1'b0;
        signExt = 1'b0;
        case (op)
            OP_SUB:        aluOp = ALU_SUB;
            OP_AND:        aluOp = ALU_AND;
            OP_OR:         aluOp = ALU_OR;
            OP_XOR:        aluOp = ALU_XOR;
            OP_SLT:        aluOp = ALU_SLT;
            OP_ORI:        begin aluOp = ALU_OR;  immOp = 1'b1; end
            OP_SW, OP_LW:  begin aluOp = ALU_ADD; immOp = 1'b1; signExt = 1'b1; end
            OP_BLT:        begin aluOp = ALU_SUB; signExt = 1'b1; end
            default:       aluOp = ALU_ADD;
        endcase
    end

    // ALU controls stay valid through MEM so the address holds while memory stalls
    always_comb begin
        ctrl = '0;
        case (state)
            S_EXEC, S_MEM: begin
                ctrl.aluSrc = immOp;
                ctrl.extOp  = signExt;
                ctrl.aluCtr = aluOp;
                if (state == S_MEM) begin
                    ctrl.memReq   = 1'b1;
                    ctrl.memWrite = (op == OP_SW);
                end
            end
            S_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = (op == OP_LW);
                ctrl.regDst   = isRType(op);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Run,
    input  logic [3:0]       Opcode,
    input  logic             MemReady,
    input  logic             AluLt,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             RegDst,
    output logic             ALUsrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ExtOp,
    output logic [2:0]       ALUctr,
    output logic             IllegalOp,
    output logic [2:0]       State,
    output logic [RET_W-1:0] RetCnt
);

    state_t     state, nextState;
    logic [3:0] opQ;
    ctrl_t      ctrl;
    logic       fetchReq, irLoad, pcLoad, takeBranch, retire, setIllegal;

    ctrl_decode uDecode (
        .state (state),
        .op    (opQ),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            opQ       <= '0;
            RetCnt    <= '0;
            IllegalOp <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_DECODE) opQ <= Opcode;
            if (retire)     RetCnt    <= RetCnt + 1'b1;
            if (setIllegal) IllegalOp <= 1'b1;
        end
    end

    always_comb begin
        nextState  = state;
        fetchReq   = 1'b0;
        irLoad     = 1'b0;
        pcLoad     = 1'b0;
        takeBranch = 1'b0;
        retire     = 1'b0;
        setIllegal = 1'b0;
        case (state)
            S_FETCH: begin
                fetchReq = Run;
                if (Run && MemReady) begin
                    irLoad    = 1'b1;
                    pcLoad    = 1'b1;
                    nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                // Illegal opcodes retire as NOPs straight from DECODE
                if (isIllegal(Opcode)) begin
                    setIllegal = 1'b1;
                    retire     = 1'b1;
                    nextState  = S_FETCH;
                end else begin
                    nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opQ == OP_BLT) begin
                    pcLoad     = AluLt;
                    takeBranch = AluLt;
                    retire     = 1'b1;
                    nextState  = S_FETCH;
                end else if (opQ == OP_LW || opQ == OP_SW) begin
                    nextState = S_MEM;
                end else begin
                    nextState = S_WB;
                end
            end
            S_MEM: begin
                if (MemReady) begin
                    if (opQ == OP_SW) begin
                        retire    = 1'b1;
                        nextState = S_FETCH;
                    end else begin
                        nextState = S_WB;
                    end
                end
            end
            S_WB: begin
                retire    = 1'b1;
                nextState = S_FETCH;
            end
            default: nextState = S_FETCH;
        endcase
    end

    // Strobes are forced low while rst is held so no partial access escapes
    assign MemReq   = !rst && (fetchReq || ctrl.memReq);
    assign MemWrite = !rst && ctrl.memWrite;
    assign IRWrite  = !rst && irLoad;
    assign PCWrite  = !rst && pcLoad;
    assign Branch   = !rst && takeBranch;
    assign RegDst   = !rst && ctrl.regDst;
    assign ALUsrc   = !rst && ctrl.aluSrc;
    assign MemtoReg = !rst && ctrl.memToReg;
    assign RegWrite = !rst && ctrl.regWrite;
    assign ExtOp    = !rst && ctrl.extOp;
    assign ALUctr   = rst ? 3'b000 : ctrl.aluCtr;
    assign State    = state;

endmodule
